// File: rtl/fetch_queue_n.sv
// Decoupled fetch: issues one outstanding imem request at a time and queues {pc, inst} in order.
// Latency: request accept -> response (>=1 cycle) -> inst_valid next cycle; redirect flushes everything.
module fetch_queue_n #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            inflight_q, inflight_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;

  logic [ILEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];

  logic            req_fire, resp_hit, push, pop;
  logic [CW:0]     used;
  logic            unused_redir_lsb;

  assign unused_redir_lsb = ^redirect_pc[1:0];

  // Credit counts the in-flight response as an occupied slot, so a push can never overflow.
  assign used           = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign imem_req_valid = rst && !redirect_valid && (!inflight_q || imem_resp_valid) &&
                          (used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;

  assign inst_valid = rst && (count_q != '0);
  assign inst_data  = data_q[head_q];
  assign inst_pc    = pc_q[head_q];

  assign req_fire = imem_req_valid && imem_req_ready;
  assign resp_hit = imem_resp_valid && inflight_q;
  assign push     = resp_hit && !kill_q && !redirect_valid;
  assign pop      = inst_valid && inst_ready && !redirect_valid;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    kill_d     = kill_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    if (redirect_valid) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      // A response landing in the redirect cycle is simply dropped; otherwise kill the late one.
      inflight_d = inflight_q && !imem_resp_valid;
      kill_d     = inflight_q && !imem_resp_valid;
    end else begin
      if (req_fire) begin
        inflight_d = 1'b1;
        kill_d     = 1'b0;
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        pend_pc_d  = fetch_pc_q;
      end else if (resp_hit) begin
        inflight_d = 1'b0;
        kill_d     = 1'b0;
      end
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= RESET_PC;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail_q] <= imem_resp_data;
      pc_q[tail_q]   <= pend_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_queue_n.sv
// Bench for fetch_queue_n: directed table, hand sequences, random traffic vs a sequential-stream model.
module tb_fetch_queue_n;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  fetch_queue_n #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // Stream model: requests and deliveries are both consecutive words from the last restart point.
  logic [31:0] exp_req, exp_pop;
  int          issued, popped, total_pops;
  logic        rst_drv = 1'b0;
  // Memory model: one slot, responds mem_lat cycles after acceptance.
  bit          mem_busy = 0;
  int          mem_cnt = 0, mem_lat = 1;
  logic [31:0] mem_addr = '0;
  // Per-cycle captures.
  bit          fired, popped_now, cap_req_vld, cap_inst_vld, cap_resp;
  logic [31:0] fired_addr, cap_inst_pc;

  task automatic cycle(input logic ir, input logic rr, input logic rd, input logic [31:0] rpc);
    bit rv;
    @(negedge clk);
    rst            = rst_drv;
    inst_ready     = ir;
    imem_req_ready = rr;
    redirect_valid = rd;
    redirect_pc    = rpc;
    rv             = mem_busy && (mem_cnt == 0);
    imem_resp_valid = rv;
    imem_resp_data  = rv ? f(mem_addr) : 32'h0;
    #1;
    fired        = imem_req_valid && rr;
    fired_addr   = imem_req_addr;
    cap_req_vld  = imem_req_valid;
    cap_inst_vld = inst_valid;
    cap_inst_pc  = inst_pc;
    cap_resp     = rv;
    popped_now   = 0;
    if (!rst) begin
      chk("reset_req_vld", 32'(imem_req_valid), 32'd0);
      chk("reset_inst_vld", 32'(inst_valid), 32'd0);
    end else begin
      if (inst_valid && ir) begin
        chk("pop_pc", inst_pc, exp_pop);
        chk("pop_data", inst_data, f(exp_pop));
        exp_pop += 32'd4;
        popped++;
        total_pops++;
        popped_now = 1;
      end
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
      if (fired) begin
        exp_req += 32'd4;
        issued++;
        chk("credit", 32'(issued - (popped - int'(popped_now)) <= DEPTH), 32'd1);
      end
      if (rd) begin
        chk("redir_no_req", 32'(imem_req_valid), 32'd0);
        exp_req = {rpc[31:2], 2'b00};
        exp_pop = {rpc[31:2], 2'b00};
        issued  = 0;
        popped  = 0;
      end
    end
    if (fired) begin
      mem_busy = 1;
      mem_cnt  = mem_lat - 1;
      mem_addr = fired_addr;
    end else if (rv) begin
      mem_busy = 0;
    end else if (mem_busy && mem_cnt > 0) begin
      mem_cnt--;
    end
  endtask

  task automatic do_reset(input int n, input bit keep_mem);
    rst_drv = 1'b0;
    exp_req = RPC;
    exp_pop = RPC;
    issued  = 0;
    popped  = 0;
    if (!keep_mem) mem_busy = 0;
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    rst_drv = 1'b1;
  endtask

  typedef struct {
    logic        req_vld;
    logic [31:0] req_addr;
    logic        inst_vld;
    logic [31:0] inst_pc;
  } vec_t;

  initial begin
    vec_t        tbl[5];
    int          n;
    bit          seen;
    logic [31:0] a0;

    tbl[0] = '{1'b1, 32'h8000_0000, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'h8000_0004, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000};
    tbl[3] = '{1'b1, 32'h8000_000c, 1'b1, 32'h8000_0004};
    tbl[4] = '{1'b1, 32'h8000_0010, 1'b1, 32'h8000_0008};

    // Streaming from reset with 1-cycle memory.
    do_reset(3, 0);
    mem_lat = 1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      chk($sformatf("tbl%0d_req_vld", i), 32'(cap_req_vld), 32'(tbl[i].req_vld));
      chk($sformatf("tbl%0d_req_addr", i), fired_addr, tbl[i].req_addr);
      chk($sformatf("tbl%0d_inst_vld", i), 32'(cap_inst_vld), 32'(tbl[i].inst_vld));
      if (tbl[i].inst_vld) chk($sformatf("tbl%0d_inst_pc", i), cap_inst_pc, tbl[i].inst_pc);
    end

    // Fill with decode stalled, then drain.
    do_reset(2, 0);
    mem_lat = 1;
    n = 0;
    repeat (8) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      if (fired) n++;
    end
    chk("full_accepts", 32'(n), 32'd4);
    chk("full_req_vld", 32'(cap_req_vld), 32'd0);
    chk("full_inst_vld", 32'(cap_inst_vld), 32'd1);
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (fired) begin
        seen = 1;
        chk("resume_addr", fired_addr, 32'h8000_0010);
      end
    end
    if (!seen) chk("resume_timeout", 32'd0, 32'd1);
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect while a 3-cycle fetch is in flight.
    do_reset(2, 0);
    mem_lat = 3;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h8000_0102);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_queue_empty", 32'(cap_inst_vld), 32'd0);
    seen = fired;
    if (fired) chk("redir_first_addr", fired_addr, 32'h8000_0100);
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (fired) begin
        seen = 1;
        chk("redir_first_addr", fired_addr, 32'h8000_0100);
      end
    end
    if (!seen) chk("redir_req_timeout", 32'd0, 32'd1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (cap_inst_vld) begin
        seen = 1;
        chk("redir_first_pc", cap_inst_pc, 32'h8000_0100);
      end
    end
    if (!seen) chk("redir_pop_timeout", 32'd0, 32'd1);

    // Redirect coinciding with a response and a pop.
    do_reset(2, 0);
    mem_lat = 1;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h8000_0200);
    chk("same_cyc_resp", 32'(cap_resp), 32'd1);
    chk("same_cyc_pop", 32'(cap_inst_vld), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("same_cyc_next_req", 32'(fired), 32'd1);
    chk("same_cyc_next_addr", fired_addr, 32'h8000_0200);
    chk("same_cyc_empty", 32'(cap_inst_vld), 32'd0);

    // Memory stall holds the address, then wrap at the top of the address space.
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    a0 = fired_addr;
    chk("stall_addr", a0, 32'h8000_0204);
    repeat (4) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      chk("stall_stable", imem_req_addr, a0);
    end
    cycle(1'b1, 1'b1, 1'b1, 32'hffff_fffe);
    n = 0;
    for (int i = 0; i < 10 && n < 2; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (fired) begin
        chk(n == 0 ? "wrap_addr0" : "wrap_addr1", fired_addr, n == 0 ? 32'hffff_fffc : 32'h0);
        n++;
      end
    end
    if (n < 2) chk("wrap_timeout", 32'd0, 32'd1);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Reset mid-stream with two entries queued and a slow fetch in flight.
    do_reset(2, 0);
    mem_lat = 1;
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    mem_lat = 8;
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("pre_reset_vld", 32'(cap_inst_vld), 32'd1);
    do_reset(2, 1);
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      chk("post_reset_empty", 32'(cap_inst_vld), 32'd0);
      if (cap_resp) seen = 1;
    end
    if (!seen) chk("stale_resp_timeout", 32'd0, 32'd1);
    mem_lat = 1;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stale_ignored", 32'(cap_inst_vld), 32'd0);
    chk("post_reset_addr", fired_addr, RPC);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Random traffic.
    do_reset(2, 0);
    total_pops = 0;
    for (int i = 0; i < 3000; i++) begin
      mem_lat = $urandom_range(1, 4);
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 39) == 0), $urandom);
    end
    repeat (20) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("random_progress", 32'(total_pops > 500), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_queue_n.md
Name: fetch_queue_n

Overview:
- Decoupled instruction-fetch unit; the next generation of the PC/next-PC/instruction-memory path of the single-cycle core.
- Replaces the combinational instruction lookup with a valid/ready request to instruction memory that has variable response latency, plus a parametrised in-order instruction queue.
- Accepts redirects (branch/jump/trap) from the execute side, which flush the queue and any in-flight fetch.
- Sits between instruction memory and the decode stage of the multi-cycle/pipelined core.

Parameters:
XLEN, 32, address/PC width
ILEN, 32, instruction width
DEPTH, 4, queue entries; power of two, minimum 2
RESET_PC, 32'h8000_0000, first fetch address after reset; bits [1:0] must be 0

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-low reset; sampled on rising edge of clk
redirect_valid  in  1  flush queue and restart fetch at redirect_pc
redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored and treated as 0
imem_req_valid  out  1  fetch request
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address
imem_resp_valid  in  1  response data valid; in order, at least 1 cycle after acceptance
imem_resp_data  in  ILEN  fetched instruction
inst_valid  out  1  queue head valid
inst_ready  in  1  decode consumes head
inst_data  out  ILEN  head instruction
inst_pc  out  XLEN  head PC

Behaviour:
- Reset (rst==0 at clk edge): count=0, head=tail=0, inflight=0, kill=0, fetch_pc=RESET_PC.
  - imem_req_valid=0 and inst_valid=0 while rst==0.
  - Reset mid-transaction discards everything; a response arriving after reset release with inflight==0 is ignored.
- At most one outstanding request (inflight flag).
- imem_req_valid = rst && !redirect_valid && (!inflight || imem_resp_valid) && (count + inflight) < DEPTH.
- imem_req_addr = fetch_pc, combinational. No hold requirement before acceptance; memory samples only on valid&&ready.
- Request handshake (valid&&ready): inflight=1, kill=0, fetch_pc += 4, wrapping modulo 2^XLEN.
- Response with inflight==1 and kill==0: push {fetch address of that request, imem_resp_data} at tail.
  - The queue stores the PC per entry, so the request address must be retained in a pending-PC register.
- Response with kill==1: discarded. kill clears, and inflight clears unless a new request fires the same cycle.
- Response with inflight==0: ignored, no state change.
- Output side:
  - inst_valid = (count != 0); inst_data and inst_pc are the head entry.
  - Pop on inst_valid && inst_ready.
  - No bypass: minimum latency is request accept -> response (>=1 cycle) -> inst_valid on the next cycle.
- Simultaneous push and pop: count unchanged, head and tail both advance (mod DEPTH).
- Full: count==DEPTH cannot occur with a live inflight response, because of the credit rule (count + inflight) < DEPTH. Overflow is impossible by construction; a bench assertion checks it.
- Redirect (redirect_valid==1), highest priority:
  - Next state: count=0, head=tail=0, fetch_pc={redirect_pc[XLEN-1:2],2'b00}.
  - kill=inflight, computed after any response arriving this cycle: if the pending response arrives in the redirect cycle it is dropped and kill=0.
  - No request is issued that cycle.
  - A pop in the same cycle is treated as consumed; the queue is cleared regardless.
- Back-to-back throughput: with 1-cycle memory latency and inst_ready held high, one instruction per cycle in steady state.

Test Plan:
- Reset release, 1-cycle memory, inst_ready=1 -> requests at 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles; inst_valid first asserts 2 cycles after the first accept, then every cycle, with inst_pc matching.
- inst_ready=0, DEPTH=4 -> exactly 4 requests accepted, count reaches 4, imem_req_valid stays 0. Raise inst_ready -> entries drain in order, and fetching resumes at 0x8000_0010.
- Redirect to 0x8000_0102 while a request is in flight with 3-cycle latency -> queue empty next cycle; late response dropped; next accepted address 0x8000_0100; first delivered inst_pc is 0x8000_0100.
- Redirect in the same cycle as the response and a pop -> response dropped, kill=0, request to the redirect target issued the following cycle.
- imem_req_ready held low 5 cycles -> imem_req_addr stable, no fetch_pc advance. fetch_pc=0xFFFF_FFFC after redirect -> next address 0x0000_0000 (wrap).
- Assert rst=0 mid-stream with queue at 2 entries and a request in flight -> inst_valid=0 next cycle; after release the first request goes to RESET_PC and the stale response is ignored.
